// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display arbiter and its helpers.
package display_pkg;

  localparam int VAL_W = 16;
  localparam int CLS_W = 4;

  localparam logic [VAL_W-1:0] BLANK_VAL = '0;
  localparam logic [CLS_W-1:0] BLANK_CLS = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searched from ptr+1 upward, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any_req
);

  int cand;

  // NOTE: every output gets a default before the loop so no path leaves a
  // value unassigned; otherwise synthesis infers latches.
  always_comb begin
    onehot  = '0;
    idx     = '0;
    any_req = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any_req && req[cand]) begin
        any_req      = 1'b1;
        idx          = IDX_W'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner selection for the 8-digit display with minimum dwell and optional blank gap.
module display_arbiter
  import display_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int BLANK_CYCLES = 1_000_000,
  parameter int CNT_W        = 27
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [VAL_W*NUM_REQ-1:0] data_in,
  input  logic [CLS_W*NUM_REQ-1:0] cls_in,
  input  logic                     hold,
  output logic [NUM_REQ-1:0]       grant,
  output logic [VAL_W-1:0]         F,
  output logic [CLS_W-1:0]         Q,
  output logic                     disp_valid
);

  localparam int IDX_W      = $clog2(NUM_REQ);
  localparam bit HAS_BLANK  = (BLANK_CYCLES > 0);
  localparam int BLANK_LAST = HAS_BLANK ? BLANK_CYCLES - 1 : 0;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .onehot  (pick_onehot),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  logic [VAL_W-1:0] owner_val, pick_val;
  logic [CLS_W-1:0] owner_cls, pick_cls;

  always_comb begin
    owner_val = data_in[owner * VAL_W +: VAL_W];
    owner_cls = cls_in[owner * CLS_W +: CLS_W];
    pick_val  = data_in[pick_idx * VAL_W +: VAL_W];
    pick_cls  = cls_in[pick_idx * CLS_W +: CLS_W];
  end

  logic owner_req, others, expire, end_tenure, blank_done, take;

  // Owner drop wins over dwell and hold; expiry only ends the tenure if someone else waits.
  always_comb begin
    owner_req  = |(req & grant);
    others     = |(req & ~grant);
    expire     = (cnt == CNT_W'(DWELL_CYCLES - 1)) && !hold;
    end_tenure = !owner_req || (expire && others);
    blank_done = (cnt == CNT_W'(BLANK_LAST));
    take       = pick_any && ((state == IDLE) ||
                              (state == SHOW  && end_tenure && !HAS_BLANK) ||
                              (state == BLANK && blank_done));
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      grant      <= '0;
      F          <= BLANK_VAL;
      Q          <= BLANK_CLS;
      disp_valid <= 1'b0;
    end else if (take) begin
      state      <= SHOW;
      cnt        <= '0;
      ptr        <= pick_idx;
      owner      <= pick_idx;
      grant      <= pick_onehot;
      F          <= pick_val;
      Q          <= pick_cls;
      disp_valid <= 1'b1;
    end else begin
      case (state)
        IDLE: ;
        SHOW: begin
          if (end_tenure) begin
            state      <= HAS_BLANK ? BLANK : IDLE;
            cnt        <= '0;
            grant      <= '0;
            F          <= BLANK_VAL;
            Q          <= BLANK_CLS;
            disp_valid <= 1'b0;
          end else begin
            F <= owner_val;
            Q <= owner_cls;
            if (expire)     cnt <= '0;
            else if (!hold) cnt <= cnt + 1'b1;
          end
        end
        BLANK: begin
          if (blank_done) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with NUM_REQ=4, DWELL_CYCLES=8, BLANK_CYCLES=2.
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] data_in;
  logic [15:0] cls_in;
  logic        hold;
  logic [3:0]  grant;
  logic [15:0] F;
  logic [3:0]  Q;
  logic        disp_valid;

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] vals [4] = '{16'h1234, 16'h5555, 16'hAAAA, 16'h0F0F};
  logic [3:0]  clss [4] = '{4'd3, 4'd1, 4'd2, 4'd7};
  int          order [4] = '{0, 1, 3, 0};

  display_arbiter #(
    .NUM_REQ(4), .DWELL_CYCLES(8), .BLANK_CYCLES(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .cls_in(cls_in),
    .hold(hold), .grant(grant), .F(F), .Q(Q), .disp_valid(disp_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [15:0] f,
                           input logic [3:0] q, input logic v);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".F"}, 32'(F), 32'(f));
    check({tag, ".Q"}, 32'(Q), 32'(q));
    check({tag, ".valid"}, 32'(disp_valid), 32'(v));
  endtask

  task automatic check_owner(input string tag, input int o);
    check_out(tag, 4'(1 << o), vals[o], clss[o], 1'b1);
  endtask

  task automatic check_blank(input string tag);
    check_out(tag, 4'b0, 16'h0, 4'h0, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 4'b0;
    hold    = 1'b0;
    data_in = {vals[3], vals[2], vals[1], vals[0]};
    cls_in  = {clss[3], clss[2], clss[1], clss[0]};
    #2;
    check_blank("in_reset");
    step(); step();
    rst_n = 1'b1;

    // Idle with no requests stays blank.
    for (int i = 0; i < 5; i++) begin
      step();
      check_blank("idle");
    end

    // Single requester: 1-cycle latency, live data tracking, dwell restarts without a gap.
    req = 4'b0001;
    step();
    check_owner("first_grant", 0);
    data_in[15:0] = 16'h4321;
    step();
    check("track_F", 32'(F), 32'h4321);
    data_in[15:0] = vals[0];
    for (int i = 0; i < 20; i++) begin
      step();
      check("solo_grant", 32'(grant), 32'h1);
      check("solo_valid", 32'(disp_valid), 32'h1);
    end

    // Constant 1011: owners 0,1,3,0 with 8-cycle tenures and 2-cycle gaps.
    #2 rst_n = 1'b0;
    req = 4'b1011;
    step();
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        check_owner("rr_show", order[t]);
      end
      if (t < 3) begin
        for (int c = 0; c < 2; c++) begin
          step();
          check_blank("rr_blank");
        end
      end
    end
    step();
    check_blank("rr_after_last");

    // Owner 1 drops mid-tenure with 3 pending.
    rst_n = 1'b0;
    req   = 4'b1010;
    step();
    rst_n = 1'b1;
    step(); check_owner("drop_t1", 1);
    step(); check_owner("drop_t2", 1);
    step(); check_owner("drop_t3", 1);
    req = 4'b1000;
    step(); check_blank("drop_blank1");
    step(); check_blank("drop_blank2");
    step(); check_owner("drop_next", 3);

    // BLANK exit with nothing requested returns to IDLE.
    req = 4'b0000;
    step(); check_blank("empty_blank1");
    step(); check_blank("empty_blank2");
    for (int i = 0; i < 3; i++) begin
      step();
      check_blank("empty_idle");
    end

    // Hold extends owner 0 to 28 cycles while 2 waits.
    rst_n = 1'b0;
    req   = 4'b0101;
    hold  = 1'b1;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 28; i++) begin
      step();
      check_owner("hold_show", 0);
      if (i == 20) hold = 1'b0;
    end
    step(); check_blank("hold_blank1");
    step(); check_blank("hold_blank2");
    step(); check_owner("hold_next", 2);

    // Asynchronous reset mid-SHOW, then reset pointer favours lowest pending index.
    step();
    rst_n = 1'b0;
    #1;
    check_blank("async_reset");
    req = 4'b0100;
    step();
    rst_n = 1'b1;
    step(); check_owner("post_reset", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
